// File: rtl/sobel_window.sv
// ============================================================================
// Module   : sobel_window
// Purpose  : Streaming 3x3 neighbourhood generator built on two line buffers.
//            The optional sof_in port is enabled by defining SOBEL_WINDOW_SOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_window #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef SOBEL_WINDOW_SOF_EN
   input  logic                    sof_in,
`endif
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    valid_in,
   output logic [9*DATA_WIDTH-1:0] data_out,
   output logic                    valid_out,
   output logic                    frame_done
);

   localparam int c_COL_W = $clog2(IMG_WIDTH);
   localparam int c_ROW_W = $clog2(IMG_HEIGHT);
   localparam int c_DW    = DATA_WIDTH;

   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
   localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

   typedef enum logic [0:0] {
      ST_PRIME  = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   state_t                    w_state;
   logic [c_COL_W-1:0]        r_col;
   logic [c_ROW_W-1:0]        r_row;
   logic [c_COL_W-1:0]        w_col;
   logic [c_ROW_W-1:0]        w_row;
   logic                      w_sof;
   logic                      w_col_last;
   logic                      w_row_last;
   logic                      w_emit;
   logic [c_DW-1:0]           w_top;
   logic [c_DW-1:0]           w_mid;
   logic [9*c_DW-1:0]         r_win;
   logic [9*c_DW-1:0]         w_win_next;
   logic [c_DW-1:0]           r_lb0 [IMG_WIDTH];
   logic [c_DW-1:0]           r_lb1 [IMG_WIDTH];

`ifdef SOBEL_WINDOW_SOF_EN
   assign w_sof = valid_in & sof_in;
`else
   assign w_sof = 1'b0;
`endif

   // Effective position/state of the pixel being accepted (start-of-frame overrides)
   always_comb begin
      w_col   = r_col;
      w_row   = r_row;
      w_state = r_state;
      if (w_sof) begin
         w_col   = '0;
         w_row   = '0;
         w_state = ST_PRIME;
      end
   end

   assign w_col_last = (w_col == c_COL_LAST);
   assign w_row_last = (w_row == c_ROW_LAST);
   assign w_top      = r_lb1[w_col];
   assign w_mid      = r_lb0[w_col];
   assign w_emit     = valid_in && (w_state == ST_STREAM) && (w_col >= c_COL_TWO);

   // Shift columns left; new right column is {row r-2, row r-1, row r}
   assign w_win_next = {data_in,
                        r_win[8*c_DW +: c_DW], r_win[7*c_DW +: c_DW],
                        w_mid,
                        r_win[5*c_DW +: c_DW], r_win[4*c_DW +: c_DW],
                        w_top,
                        r_win[2*c_DW +: c_DW], r_win[1*c_DW +: c_DW]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_PRIME;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (valid_in) begin
         w_state_next = w_state;
         case (w_state)
            ST_PRIME:  if (w_row == c_ROW_ONE && w_col_last) w_state_next = ST_STREAM;
            ST_STREAM: if (w_row_last && w_col_last)         w_state_next = ST_PRIME;
            default:   w_state_next = ST_PRIME;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_win      <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= w_emit;
         frame_done <= w_emit && w_row_last && w_col_last;
         if (valid_in) begin
            r_win <= w_win_next;
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
         end
         if (w_emit) begin
            data_out <= w_win_next;
         end
      end
   end

   // Line buffer contents are don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (valid_in) begin
         r_lb1[w_col] <= r_lb0[w_col];
         r_lb0[w_col] <= data_in;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sobel_window.sv
// ============================================================================
// Module   : tb_sobel_window
// Purpose  : Scoreboard bench for sobel_window on a 4x4 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_window;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;

   typedef struct {
      logic [9*DW-1:0] win;
      bit              fd;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            sof_in;
   logic [DW-1:0]   data_in;
   logic            valid_in;
   logic [9*DW-1:0] data_out;
   logic            valid_out;
   logic            frame_done;

   sobel_window #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef SOBEL_WINDOW_SOF_EN
      .sof_in     (sof_in),
`endif
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int              n_chk = 0;
   int              n_fail = 0;
   exp_t            exp_q[$];
   logic [DW-1:0]   img [H][W];
   int              m_r = 0;
   int              m_c = 0;
   int              exp_win = 0;
   int              exp_fd = 0;
   int              dut_win = 0;
   int              dut_fd = 0;
   logic [9*DW-1:0] last_exp = '0;
   bit              have_last = 0;
   bit              started = 0;
   bit              acc_q = 0;

   always @(posedge clk) acc_q <= (valid_in === 1'b1) && (rst === 1'b0);

   // Monitor: pops the scoreboard whenever the DUT presents a window
   always @(negedge clk) begin
      if (started && rst === 1'b0) begin
         if (!acc_q) begin
            n_chk++;
            if (valid_out !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_valid: valid_out=%b required 0", valid_out);
            end
         end
         if (valid_out === 1'b1) begin
            dut_win++;
            if (frame_done === 1'b1) dut_fd++;
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_window: got %h with empty scoreboard", data_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (data_out !== e.win) begin
                  n_fail++;
                  $display("FAIL window: got %h required %h", data_out, e.win);
               end
               n_chk++;
               if (frame_done !== e.fd) begin
                  n_fail++;
                  $display("FAIL frame_done: got %b required %b", frame_done, e.fd);
               end
               last_exp  = e.win;
               have_last = 1;
            end
         end else begin
            n_chk++;
            if (frame_done !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_frame_done: got %b required 0", frame_done);
            end
            if (have_last) begin
               n_chk++;
               if (data_out !== last_exp) begin
                  n_fail++;
                  $display("FAIL data_hold: got %h required %h", data_out, last_exp);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: stores the frame as an image and cuts the 3x3 neighbourhood
   task automatic send_pixel(input logic [DW-1:0] v, input bit sof);
      exp_t e;
      if (sof) begin
         m_r = 0;
         m_c = 0;
      end
      img[m_r][m_c] = v;
      if (m_r >= 2 && m_c >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[DW*(3*i+j) +: DW] = img[m_r-2+i][m_c-2+j];
         e.fd = (m_r == H-1) && (m_c == W-1);
         exp_q.push_back(e);
         exp_win++;
         if (e.fd) exp_fd++;
      end
      m_c++;
      if (m_c == W) begin
         m_c = 0;
         m_r = (m_r == H-1) ? 0 : m_r + 1;
      end
      valid_in = 1'b1;
      data_in  = v;
      sof_in   = sof;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = DW'($urandom);
      sof_in   = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit gapped, input bit rnd);
      for (int k = 0; k < W*H; k++) begin
         send_pixel(rnd ? DW'($urandom) : DW'(base + k), 1'b0);
         if (gapped) idle($urandom_range(0, 3));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_r = 0;
      m_c = 0;
      exp_q.delete();
      last_exp = '0;
      idle(2);
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      data_in  = 'x;
      valid_in = 'x;
      sof_in   = 'x;
      idle(3);
      n_chk++;
      if (data_out !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", data_out);
      end
      n_chk++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b required 0", valid_out);
      end
      n_chk++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_frame_done: got %b required 0", frame_done);
      end
      valid_in = 1'b0;
      data_in  = '0;
      sof_in   = 1'b0;
      rst      = 1'b0;
      last_exp  = '0;
      have_last = 1;
      started   = 1;
      idle(10);

      send_frame(0, 1'b0, 1'b0);
      idle(3);
      send_frame(0, 1'b1, 1'b0);
      idle(2);
      send_frame(100, 1'b0, 1'b0);
      send_frame(0, 1'b1, 1'b1);
      send_frame(0, 1'b0, 1'b1);
      idle(2);

      for (int k = 0; k < 10; k++) send_pixel(DW'(200 + k), 1'b0);
      do_reset();
      send_frame(0, 1'b0, 1'b0);
      idle(2);

`ifdef SOBEL_WINDOW_SOF_EN
      for (int k = 0; k < 6; k++) send_pixel(DW'(50 + k), 1'b0);
      send_pixel(DW'(0), 1'b1);
      for (int k = 1; k < W*H; k++) send_pixel(DW'(k), 1'b0);
      idle(2);
      for (int k = 0; k < 13; k++) send_pixel(DW'($urandom), 1'b0);
      send_pixel(DW'(30), 1'b1);
      for (int k = 1; k < W*H; k++) begin
         send_pixel(DW'(30 + k), 1'b0);
         idle($urandom_range(0, 2));
      end
`endif
      idle(5);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d windows outstanding, required 0", exp_q.size());
      end
      n_chk++;
      if (dut_win != exp_win) begin
         n_fail++;
         $display("FAIL window_count: got %0d required %0d", dut_win, exp_win);
      end
      n_chk++;
      if (dut_fd != exp_fd) begin
         n_fail++;
         $display("FAIL frame_done_count: got %0d required %0d", dut_fd, exp_fd);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sobel_window.md
# sobel_window

Streaming 3x3 neighbourhood generator between `rgb2luma` and the Sobel gradient stage. Accepts one raster-order luma pixel per `valid_in` and buffers the two previous image rows in internal line buffers. Emits a packed 3x3 window for every pixel position whose full neighbourhood lies inside the frame. There is no backpressure: every pixel presented with `valid_in` is consumed.

## Interface
- `IMG_WIDTH`, 640: pixels per row, minimum 3.
- `IMG_HEIGHT`, 480: rows per frame, minimum 3.
- `DATA_WIDTH`, 8: bits per luma pixel.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  luma pixel, raster order.
- `valid_in`  in  1  `data_in` valid this cycle; pixel consumed.
- `data_out`  out  9*DATA_WIDTH  window; `data_out[DATA_WIDTH*k +: DATA_WIDTH]` = w[k], k = 3*i + j; i = row (0 = top/oldest), j = column (0 = left/oldest).
- `valid_out`  out  1  `data_out` holds a new window this cycle.
- `frame_done`  out  1  one-cycle pulse with the last window of a frame.

## Operation
- Counters:
  - `col` runs 0..IMG_WIDTH-1; the accepted pixel at `col` = IMG_WIDTH-1 wraps it to 0 and increments `row`.
  - `row` runs 0..IMG_HEIGHT-1; the accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) wraps both to 0.
- Line buffers `lb0` (row r-1) and `lb1` (row r-2), IMG_WIDTH entries each. For each accepted pixel at `col` c:
  - read `lb0[c]` and `lb1[c]`;
  - write `lb1[c]` <= old `lb0[c]` and `lb0[c]` <= `data_in`.
- Window register: on each accepted pixel, the columns shift left and the new right column is {`lb1[c]`, `lb0[c]`, `data_in`} (top to bottom).
- State machine:
  - PRIME (row < 2): no output. The accepted pixel at (1, IMG_WIDTH-1) moves the state to STREAM.
  - STREAM (row >= 2): outputs enabled. The accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) moves the state back to PRIME.
- Emit condition: state STREAM and c >= 2. The emitted window is centred on (r-1, c-1). Per frame, exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are emitted.
- Row wrap: stale columns from the previous row remain in the window register at c = 0 and c = 1, but output is suppressed there, so they are never observed.
- Frame boundary: line buffers are not cleared. Rows from the previous frame are never emitted because rows 0-1 of the new frame pass through PRIME.
- `valid_in` low: counters, state, buffers and `data_out` hold; `valid_out` and `frame_done` are 0.
- Arithmetic: none. Pixels are moved unmodified.

## Timing
- Reset values:
  - `data_out` = 0, `valid_out` = 0, `frame_done` = 0;
  - `col` = 0, `row` = 0, state PRIME, window register = 0;
  - line-buffer contents are not reset (don't care).
- Latency: `valid_out` and `data_out` update on the clock edge that accepts the pixel at (r, c), i.e. they are registered one cycle after the input.
- `valid_out` is high for exactly one cycle per emitted window; `data_out` holds its value until the next emission.
- `frame_done` is high in the same cycle as `valid_out` for the window centred on (IMG_HEIGHT-2, IMG_WIDTH-2).
- Back-to-back `valid_in` is sustained at one pixel per cycle; arbitrary gaps are permitted.
- `rst` mid-frame: all state returns to its reset value immediately. The next accepted pixel is (0,0) of a new frame, and no partial-frame window appears after reset.

## Configuration
- `SOBEL_WINDOW_SOF_EN` defined: adds port `sof_in`  in  1.
  - When `valid_in` && `sof_in`, the pixel is taken as (0,0): `col`/`row` are forced to 0 and the state to PRIME before the pixel is processed.
  - A truncated previous frame produces no `frame_done`.
  - `sof_in` is ignored when `valid_in` = 0.
- Not defined: no `sof_in` port; position is derived purely from counting accepted pixels.

## Test plan
- Reset check: assert `rst` with X on the inputs -> `data_out` = 0, `valid_out` = 0, `frame_done` = 0; no output for 10 idle cycles.
- Small frame: IMG_WIDTH = 4, IMG_HEIGHT = 4, pixels 0..15 back-to-back.
  - Exactly 4 windows, emitted after pixels 10, 11, 14 and 15.
  - First window = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}.
  - `frame_done` only with the last window.
- Gapped input: same frame with `valid_in` toggled randomly -> identical window sequence; `data_out` holds during gaps; `valid_out` is never high in a gap cycle.
- Consecutive frames: second frame with pixel values 100+k -> first window {100,101,102,104,105,106,108,109,110}, with no frame-1 values in any second-frame window.
- Mid-frame reset: pulse `rst` after pixel 9, then send a full 4x4 frame -> exactly 4 correct windows and one `frame_done`.
- With `SOBEL_WINDOW_SOF_EN`: send 6 pixels, then `sof_in` with pixel 0 of a full frame -> exactly 4 correct windows and one `frame_done`.
